// File: rtl/fractal_seq_pkg.sv
// Shared types and widths for the fractal frame sequencer.
// Imported by the sequencer top and its parameter shadow.
package fractal_seq_pkg;

    localparam int PARAM_W = 32;
    localparam int MODE_W  = 4;
    localparam int LINE_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/fractal_param_shadow.sv
// Active generator parameters plus the pending-commit flag.
// Updated only when the sequencer strobes i_load in its LOAD cycle.
module fractal_param_shadow
    import fractal_seq_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_commit,
    input  logic               i_load,
    input  logic               i_animate,
    input  logic [PARAM_W-1:0] i_cfg_x0,
    input  logic [PARAM_W-1:0] i_cfg_y0,
    input  logic [PARAM_W-1:0] i_cfg_dx,
    input  logic [PARAM_W-1:0] i_cfg_dy,
    input  logic [PARAM_W-1:0] i_cfg_cr,
    input  logic [PARAM_W-1:0] i_cfg_ci,
    input  logic [PARAM_W-1:0] i_cfg_cr_step,
    input  logic [PARAM_W-1:0] i_cfg_ci_step,
    input  logic [MODE_W-1:0]  i_cfg_mode,
    output logic [PARAM_W-1:0] o_x0,
    output logic [PARAM_W-1:0] o_y0,
    output logic [PARAM_W-1:0] o_dx,
    output logic [PARAM_W-1:0] o_dy,
    output logic [PARAM_W-1:0] o_cr,
    output logic [PARAM_W-1:0] o_ci,
    output logic [MODE_W-1:0]  o_mode
);

    logic               r_pending;
    logic [PARAM_W-1:0] r_x0, r_y0, r_dx, r_dy, r_cr, r_ci;
    logic [MODE_W-1:0]  r_mode;
    logic               w_take;

    // A commit landing in the LOAD cycle itself is taken immediately
    assign w_take = r_pending | i_commit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= 1'b0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_cr      <= '0;
            r_ci      <= '0;
            r_mode    <= '0;
        end else if (i_load) begin
            r_pending <= 1'b0;
            if (w_take) begin
                r_x0   <= i_cfg_x0;
                r_y0   <= i_cfg_y0;
                r_dx   <= i_cfg_dx;
                r_dy   <= i_cfg_dy;
                r_cr   <= i_cfg_cr;
                r_ci   <= i_cfg_ci;
                r_mode <= i_cfg_mode;
            end else if (i_animate) begin
                r_cr <= r_cr + i_cfg_cr_step;
                r_ci <= r_ci + i_cfg_ci_step;
            end
        end else if (i_commit) begin
            r_pending <= 1'b1;
        end
    end

    assign o_x0   = r_x0;
    assign o_y0   = r_y0;
    assign o_dx   = r_dx;
    assign o_dy   = r_dy;
    assign o_cr   = r_cr;
    assign o_ci   = r_ci;
    assign o_mode = r_mode;

endmodule

// File: rtl/fractal_frame_sequencer.sv
// Frame-level controller: stages parameters between frames and
// sequences the generator reset through load, run and flush.
module fractal_frame_sequencer
    import fractal_seq_pkg::*;
#(
    parameter int HEIGHT       = 1080,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               ctrl_run,
    input  logic               ctrl_single,
    input  logic               ctrl_animate,
    input  logic               cfg_commit,
    input  logic [PARAM_W-1:0] cfg_x0,
    input  logic [PARAM_W-1:0] cfg_y0,
    input  logic [PARAM_W-1:0] cfg_dx,
    input  logic [PARAM_W-1:0] cfg_dy,
    input  logic [PARAM_W-1:0] cfg_cr,
    input  logic [PARAM_W-1:0] cfg_ci,
    input  logic [PARAM_W-1:0] cfg_cr_step,
    input  logic [PARAM_W-1:0] cfg_ci_step,
    input  logic [MODE_W-1:0]  cfg_mode,
    input  logic               gen_data_enable,
    input  logic               gen_line_end,
    output logic               gen_resetn,
    output logic [PARAM_W-1:0] act_x0,
    output logic [PARAM_W-1:0] act_y0,
    output logic [PARAM_W-1:0] act_dx,
    output logic [PARAM_W-1:0] act_dy,
    output logic [PARAM_W-1:0] act_cr,
    output logic [PARAM_W-1:0] act_ci,
    output logic [MODE_W-1:0]  act_mode,
    output logic               frame_done,
    output logic [31:0]        frame_count,
    output logic               busy
);

    localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(HEIGHT - 1);
    localparam logic [LINE_W-1:0] FLUSH_LAST = LINE_W'(FLUSH_CYCLES - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [LINE_W-1:0]  r_line_cnt;
    logic [LINE_W-1:0]  r_flush_cnt;
    logic               r_single_req;
    logic [31:0]        r_frame_count;
    logic               r_frame_done;
    logic               r_gen_resetn;
    logic               r_busy;

    logic               w_go;
    logic               w_line;
    logic               w_last;
    logic               w_flush_end;
    logic               w_load;

    assign w_go        = ctrl_run | r_single_req | ctrl_single;
    assign w_line      = gen_data_enable & gen_line_end;
    assign w_last      = (r_state == ST_RUN) & w_line
                         & (r_line_cnt == LINE_LAST);
    assign w_flush_end = (r_state == ST_FLUSH)
                         & (r_flush_cnt == FLUSH_LAST);
    assign w_load      = (r_state == ST_LOAD);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_go) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_flush_end)
                          w_state_nxt = w_go ? ST_LOAD : ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line
    // up with the state register rather than lagging it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= ST_IDLE;
            r_line_cnt    <= '0;
            r_flush_cnt   <= '0;
            r_single_req  <= 1'b0;
            r_frame_count <= '0;
            r_frame_done  <= 1'b0;
            r_gen_resetn  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gen_resetn <= (w_state_nxt == ST_RUN);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_frame_done <= w_last;
            if (w_last)
                r_frame_count <= r_frame_count + 32'd1;
            if (w_state_nxt == ST_LOAD)
                r_single_req <= 1'b0;
            else if (ctrl_single)
                r_single_req <= 1'b1;
            if (w_load)
                r_line_cnt <= '0;
            else if ((r_state == ST_RUN) && w_line)
                r_line_cnt <= r_line_cnt + 1'b1;
            if (r_state == ST_FLUSH)
                r_flush_cnt <= r_flush_cnt + 1'b1;
            else
                r_flush_cnt <= '0;
        end
    end

    fractal_param_shadow u_shadow (
        .i_clk         (aclk),
        .i_rst         (areset),
        .i_commit      (cfg_commit),
        .i_load        (w_load),
        .i_animate     (ctrl_animate),
        .i_cfg_x0      (cfg_x0),
        .i_cfg_y0      (cfg_y0),
        .i_cfg_dx      (cfg_dx),
        .i_cfg_dy      (cfg_dy),
        .i_cfg_cr      (cfg_cr),
        .i_cfg_ci      (cfg_ci),
        .i_cfg_cr_step (cfg_cr_step),
        .i_cfg_ci_step (cfg_ci_step),
        .i_cfg_mode    (cfg_mode),
        .o_x0          (act_x0),
        .o_y0          (act_y0),
        .o_dx          (act_dx),
        .o_dy          (act_dy),
        .o_cr          (act_cr),
        .o_ci          (act_ci),
        .o_mode        (act_mode)
    );

    assign gen_resetn  = r_gen_resetn;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign busy        = r_busy;

endmodule
